// File: rtl/pattern_player.sv
// Plays a latched symbol pattern onto a one-hot LED bank with fixed on/off timing.
// Define PLAYER_REVERSE_EN to honour the reverse-order request; otherwise play is always forward.
module pattern_player #(
  parameter int MAX_LEN    = 32,
  parameter int SYM_W      = 3,
  parameter int ON_CYCLES  = 4,
  parameter int OFF_CYCLES = 2,
  localparam int LED_W = 1 << SYM_W,
  localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1,
  localparam int TMR_W = $clog2(((ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES) + 1)
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_start,
  input  logic                     i_abort,
  input  logic [5:0]               i_len,
  input  logic [MAX_LEN*SYM_W-1:0] i_pattern,
  input  logic                     i_reverse,
  output logic [LED_W-1:0]         o_led,
  output logic                     o_busy,
  output logic                     o_done,
  output logic [IDX_W-1:0]         o_sym_idx
);

  typedef enum logic [1:0] {S_IDLE, S_ON, S_OFF, S_FIN} state_t;

  localparam logic [5:0]       MAX_L6 = 6'(MAX_LEN);
  localparam logic [TMR_W-1:0] ON_LD  = TMR_W'(ON_CYCLES - 1);
  localparam logic [TMR_W-1:0] OFF_LD = TMR_W'(OFF_CYCLES - 1);

  state_t                   r_state;
  logic [MAX_LEN*SYM_W-1:0] r_pat;
  logic [5:0]               r_len;
  logic [TMR_W-1:0]         r_tmr;
  logic [IDX_W-1:0]         r_idx;
  logic [LED_W-1:0]         r_led;
  logic                     r_busy;
  logic                     r_done;

  logic [5:0]               w_eff_len;
  logic [IDX_W-1:0]         w_first_idx;
  logic [IDX_W-1:0]         w_next_idx;
  logic                     w_last;
  logic [LED_W-1:0]         w_first_led;
  logic [LED_W-1:0]         w_next_led;

  function automatic logic [LED_W-1:0] onehot(input logic [SYM_W-1:0] s);
    return LED_W'(1) << s;
  endfunction

  assign w_eff_len = (i_len > MAX_L6) ? MAX_L6 : i_len;

`ifdef PLAYER_REVERSE_EN
  logic r_rev;
  assign w_first_idx = i_reverse ? IDX_W'(w_eff_len - 6'd1) : '0;
  assign w_next_idx  = r_rev ? r_idx - IDX_W'(1) : r_idx + IDX_W'(1);
  assign w_last      = r_rev ? (r_idx == '0) : (6'(r_idx) == r_len - 6'd1);
`else
  logic w_unused_rev;
  assign w_unused_rev = i_reverse;
  assign w_first_idx  = '0;
  assign w_next_idx   = r_idx + IDX_W'(1);
  assign w_last       = (6'(r_idx) == r_len - 6'd1);
`endif

  // First symbol comes straight from the input bus since the snapshot lands on the same edge.
  assign w_first_led = onehot(i_pattern[int'(w_first_idx)*SYM_W +: SYM_W]);
  assign w_next_led  = onehot(r_pat[int'(w_next_idx)*SYM_W +: SYM_W]);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_pat   <= '0;
      r_len   <= '0;
      r_tmr   <= '0;
      r_idx   <= '0;
      r_led   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
`ifdef PLAYER_REVERSE_EN
      r_rev   <= 1'b0;
`endif
    end else if (i_abort) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_led   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_FIN: begin
          r_state <= S_IDLE;
          r_led   <= '0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          if (i_start) begin
            r_pat <= i_pattern;
            r_len <= w_eff_len;
`ifdef PLAYER_REVERSE_EN
            r_rev <= i_reverse;
`endif
            if (w_eff_len == 6'd0) begin
              r_state <= S_FIN;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_ON;
              r_busy  <= 1'b1;
              r_idx   <= w_first_idx;
              r_led   <= w_first_led;
              r_tmr   <= ON_LD;
            end
          end
        end
        S_ON: begin
          if (r_tmr == '0) begin
            r_state <= S_OFF;
            r_led   <= '0;
            r_tmr   <= OFF_LD;
          end else begin
            r_tmr <= r_tmr - TMR_W'(1);
          end
        end
        S_OFF: begin
          if (r_tmr != '0) begin
            r_tmr <= r_tmr - TMR_W'(1);
          end else if (w_last) begin
            r_state <= S_FIN;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_state <= S_ON;
            r_idx   <= w_next_idx;
            r_led   <= w_next_led;
            r_tmr   <= ON_LD;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_led     = r_led;
  assign o_busy    = r_busy;
  assign o_done    = r_done;
  assign o_sym_idx = r_idx;

endmodule

// File: tb/tb_pattern_player.sv
// Bench for pattern_player: randomized patterns checked against a cycle-number timing model.
module tb_pattern_player;

  logic        i_clk;
  logic        i_rst_n;
  logic        i_start;
  logic        i_abort;
  logic [5:0]  i_len;
  logic [95:0] i_pattern;
  logic        i_reverse;
  logic [7:0]  o_led;
  logic        o_busy;
  logic        o_done;
  logic [4:0]  o_sym_idx;

  pattern_player dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_abort(i_abort),
    .i_len(i_len), .i_pattern(i_pattern), .i_reverse(i_reverse),
    .o_led(o_led), .o_busy(o_busy), .o_done(o_done), .o_sym_idx(o_sym_idx)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  // Model: eff_len, play direction and symbol table of the playback in flight.
  int m_L;
  bit m_rev;
  int m_sym [32];

  function automatic int ord(input int k);
    return m_rev ? (m_L - 1 - k) : k;
  endfunction

  // {led, busy, done} expected in cycle n counted from the accepting edge; P = 6, ON = 4.
  function automatic logic [9:0] exp_out(input int n);
    logic [7:0] led;
    if (n >= 1 && n <= m_L * 6) begin
      led = ((n - 1) % 6 < 4) ? (8'd1 << m_sym[ord((n - 1) / 6)]) : 8'd0;
      return {led, 1'b1, 1'b0};
    end
    if (n == m_L * 6 + 1) return {8'd0, 1'b0, 1'b1};
    return 10'd0;
  endfunction

  function automatic logic [4:0] exp_idx(input int n);
    return 5'(ord((n - 1) / 6));
  endfunction

  task automatic rand_syms();
    for (int k = 0; k < 32; k++) m_sym[k] = int'($urandom_range(7, 0));
  endtask

  task automatic scramble();
    i_pattern = {$urandom, $urandom, $urandom};
    i_len     = 6'($urandom);
    i_reverse = 1'($urandom);
  endtask

  // Drives a start request so it is sampled at the next edge; returns observing cycle 1.
  task automatic kick(input int len, input bit rev, input bit hold);
    m_L = (len > 32) ? 32 : len;
`ifdef PLAYER_REVERSE_EN
    m_rev = rev;
`else
    m_rev = 1'b0;
`endif
    i_len     = 6'(len);
    i_reverse = rev;
    for (int k = 0; k < 32; k++) i_pattern[k*3 +: 3] = 3'(m_sym[k]);
    i_start = 1'b1;
    @(posedge i_clk); #1;
    i_start = hold;
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0; i_start = 1'b0; i_abort = 1'b0;
    i_len = '0; i_pattern = '0; i_reverse = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
    chk_cnt++;
    if ({o_led, o_busy, o_done, o_sym_idx} !== 15'd0)
      $display("FAIL reset_state: got %h want 0", {o_led, o_busy, o_done, o_sym_idx});
    else pass_cnt++;
    i_rst_n = 1'b1;
    for (int n = 0; n < 3; n++) begin
      @(posedge i_clk); #1;
      chk_cnt++;
      if ({o_led, o_busy, o_done} !== 10'd0)
        $display("FAIL reset_idle c%0d: got %h want 0", n, {o_led, o_busy, o_done});
      else pass_cnt++;
    end
  endtask

  // One playback with optional noise (input churn and ignored start pulses) while busy.
  task automatic test_play(input string tag, input int len, input bit rev, input bit noisy);
    logic [9:0] e;
    kick(len, rev, 1'b0);
    for (int n = 1; n <= m_L * 6 + 3; n++) begin
      e = exp_out(n);
      chk_cnt++;
      if ({o_led, o_busy, o_done} !== e)
        $display("FAIL %s out c%0d: got %h want %h", tag, n, {o_led, o_busy, o_done}, e);
      else pass_cnt++;
      if (e[1]) begin
        chk_cnt++;
        if (o_sym_idx !== exp_idx(n))
          $display("FAIL %s idx c%0d: got %0d want %0d", tag, n, o_sym_idx, exp_idx(n));
        else pass_cnt++;
      end
      if (noisy && n <= m_L * 6) begin
        scramble();
        i_start = ($urandom_range(3, 0) == 0);
      end else begin
        i_start = 1'b0;
      end
      @(posedge i_clk); #1;
    end
  endtask

  task automatic test_abort();
    logic [9:0] e;
    rand_syms();
    m_sym[0] = 5; m_sym[1] = 0; m_sym[2] = 7;
    kick(3, 1'b0, 1'b0);
    for (int n = 1; n <= 10; n++) begin
      e = (n <= 8) ? exp_out(n) : 10'd0;
      chk_cnt++;
      if ({o_led, o_busy, o_done} !== e)
        $display("FAIL abort c%0d: got %h want %h", n, {o_led, o_busy, o_done}, e);
      else pass_cnt++;
      if (n == 10) break;
      i_abort = (n == 8);
      @(posedge i_clk); #1;
      i_abort = 1'b0;
    end
    kick(3, 1'b0, 1'b0);
    for (int n = 1; n <= 20; n++) begin
      e = exp_out(n);
      chk_cnt++;
      if ({o_led, o_busy, o_done} !== e)
        $display("FAIL abort_restart c%0d: got %h want %h", n, {o_led, o_busy, o_done}, e);
      else pass_cnt++;
      if (n == 1) begin
        chk_cnt++;
        if (o_sym_idx !== 5'd0)
          $display("FAIL abort_restart_idx: got %0d want 0", o_sym_idx);
        else pass_cnt++;
      end
      @(posedge i_clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    logic [9:0] e;
    int m;
    rand_syms();
    kick(2, 1'b0, 1'b1);
    for (int n = 1; n <= 27; n++) begin
      m = (n <= 13) ? n : n - 13;
      e = exp_out(m);
      chk_cnt++;
      if ({o_led, o_busy, o_done} !== e)
        $display("FAIL b2b c%0d: got %h want %h", n, {o_led, o_busy, o_done}, e);
      else pass_cnt++;
      if (n == 14) i_start = 1'b0;
      @(posedge i_clk); #1;
    end
  endtask

  task automatic test_reset_mid();
    rand_syms();
    kick(3, 1'b0, 1'b0);
    repeat (8) begin
      @(posedge i_clk); #1;
    end
    #3 i_rst_n = 1'b0;
    #1;
    chk_cnt++;
    if ({o_led, o_busy, o_done} !== 10'd0)
      $display("FAIL reset_mid_async: got %h want 0", {o_led, o_busy, o_done});
    else pass_cnt++;
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;
    for (int n = 0; n < 4; n++) begin
      @(posedge i_clk); #1;
      chk_cnt++;
      if ({o_led, o_busy, o_done, o_sym_idx} !== 15'd0)
        $display("FAIL reset_mid_idle c%0d: got %h want 0", n, {o_led, o_busy, o_done, o_sym_idx});
      else pass_cnt++;
    end
    kick(3, 1'b0, 1'b0);
    chk_cnt++;
    if ({o_led, o_busy, o_done} !== exp_out(1))
      $display("FAIL reset_mid_restart: got %h want %h", {o_led, o_busy, o_done}, exp_out(1));
    else pass_cnt++;
    repeat (20) begin
      @(posedge i_clk); #1;
    end
  endtask

  initial begin
    test_reset();
    rand_syms();
    m_sym[0] = 5; m_sym[1] = 0; m_sym[2] = 7;
    test_play("forward", 3, 1'b0, 1'b0);
    test_play("reverse", 3, 1'b1, 1'b0);
    test_abort();
    rand_syms();
    test_play("len0", 0, 1'b0, 1'b0);
    rand_syms();
    test_play("len40", 40, 1'b0, 1'b0);
    test_back_to_back();
    for (int r = 0; r < 8; r++) begin
      rand_syms();
      test_play("random", int'($urandom_range(40, 0)), 1'($urandom), 1'b1);
    end
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
